qubo_sweep_scheduler: RTL and testbench
=======================================

// Module: qubo_sweep_scheduler
// PURPOSE
//  Sequences the shared energy-delta datapath of the QUBO demon annealer.
//  Runs a fixed number of sweeps over all spins, in index order. For each spin it requests dE from the
//  external delta unit, applies the demon acceptance rule and issues flip commands.
//  It tracks the demon energy budget and the accepted-flip count.
//  Sits between top-level control (start/config pins) and the spin/coupling datapath.
// PARAMETERS
//  N_SPINS   8    number of spins per sweep (>=2); index width IW = $clog2(N_SPINS)
//  DW        8    demon energy width (unsigned)
//  D_MAX     255  demon energy ceiling (<= 2**DW-1)
// PORTS
//  clk          in   1      clock
//  reset        in   1      reset, synchronous, active-high
//  start        in   1      begin run; sampled in IDLE only
//  abort        in   1      cancel run; return to IDLE, no done pulse
//  demon_init   in   DW     initial demon energy, latched on accepted start
//  sweeps       in   16     sweep count, latched on accepted start
//  calc_req     out  1      request dE for spin calc_idx; held until ack
//  calc_idx     out  IW     spin index under evaluation
//  calc_ack     in   1      delta unit response valid
//  calc_delta   in   DW+1   signed dE of flipping calc_idx, valid with calc_ack
//  flip_valid   out  1      one-cycle pulse: commit flip of flip_idx
//  flip_idx     out  IW     spin to flip
//  demon_energy out  DW     current demon energy
//  accept_cnt   out  16     accepted flips this run, saturating at 16'hFFFF
//  busy         out  1      high from accepted start until DONE/abort
//  done         out  1      one-cycle pulse at normal run completion
// BEHAVIOUR
//  All outputs are registered. On reset: state=IDLE and every output is 0.
//   Reset mid-run discards the run immediately; no flip or done is emitted.
//  States: IDLE -> REQ <-> DECIDE -> DONE -> IDLE.
//  IDLE:
//   - start=1: latch demon_init and sweeps; idx=0, sweep_cnt=0, accept_cnt=0; busy=1.
//   - Next state is DONE if sweeps==0, else REQ.
//  REQ:
//   - calc_req=1, calc_idx=idx. On a cycle with calc_ack=1, capture calc_delta and go to DECIDE.
//   - calc_req drops in the cycle after the ack.
//   - calc_ack outside REQ is ignored.
//  DECIDE, one cycle:
//   - n = D - dE, computed signed in DW+2 bits.
//   - accept iff 0 <= n <= D_MAX. On accept: D<=n, flip_valid=1 next cycle with flip_idx=idx,
//     accept_cnt++ (saturating). On reject: D unchanged.
//   - dE=0 is accepted.
//   - Advance: if idx==N_SPINS-1 then idx=0 and sweep_cnt++; otherwise idx++.
//   - Next state is DONE if the sweep just completed was the last one (sweep_cnt+1==sweeps), else REQ.
//  DONE: done=1 and busy=0 for one cycle; demon_energy/accept_cnt hold until next start; -> IDLE.
//  Throughput: 2 cycles per spin when the ack arrives in the first REQ cycle.
//  start while busy: ignored.
//  abort in any non-IDLE state:
//   - Next state IDLE, busy=0, done stays 0. A pending flip_valid from the same edge is suppressed.
//  abort and start in the same IDLE cycle: abort wins, run not started.
//  Simultaneous reset with anything: reset wins.
// TESTING
//  T1 N_SPINS=4, init=5, sweeps=1, dE=+3,+3,-4,0
//     -> flips idx 0,2,3; D: 2,2,6,6; accept_cnt=3; done once.
//  T2 sweeps=0, start=1 -> done pulse 2 cycles after start, no calc_req, busy high for 1 cycle.
//  T3 init=250, D_MAX=255, dE=-10 -> reject (n=260), D stays 250, no flip_valid.
//  T4 sweeps=3, N_SPINS=4, ack delays 0..5 random -> exactly 12 requests, idx wraps 3->0, one done.
//  T5 abort while in REQ for spin 2 -> busy=0 next cycle, no done, no flip.
//     Then a fresh start runs cleanly from idx 0.
//  T6 reset asserted in DECIDE with pending accept -> all outputs 0 next cycle, no flip_valid.
//     start held during busy -> no restart.

Source files
------------

// File: rtl/qubo_sweep_scheduler.sv
// qubo_sweep_scheduler
// Drives the shared energy-delta unit of the QUBO demon annealer. It walks every spin in index
// order for a programmed number of sweeps, applies the demon acceptance rule to each returned
// dE, issues flip commands, and keeps the demon energy budget and the accepted-flip count.
module qubo_sweep_scheduler #(
    parameter int N_SPINS = 8,
    parameter int DW      = 8,
    parameter int D_MAX   = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DW-1:0]              demon_init,
    input  logic [15:0]                sweeps,
    output logic                       calc_req,
    output logic [$clog2(N_SPINS)-1:0] calc_idx,
    input  logic                       calc_ack,
    input  logic [DW:0]                calc_delta,
    output logic                       flip_valid,
    output logic [$clog2(N_SPINS)-1:0] flip_idx,
    output logic [DW-1:0]              demon_energy,
    output logic [15:0]                accept_cnt,
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(N_SPINS);
    localparam logic [DW:0] DMaxExt = (DW+1)'(D_MAX);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StReq    = 2'd1;
    localparam logic [1:0] StDecide = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]           state_q;
    logic [15:0]          sweeps_q;
    logic [15:0]          sweep_cnt_q;
    logic [DW:0]          delta_q;

    logic signed [DW+1:0] n_val;
    logic                 accept;
    logic                 last_spin;
    logic                 last_sweep;

    // Candidate demon energy and acceptance decision for the captured dE.
    always_comb begin
        // Two extra bits keep D - dE exact for any D in [0, 2**DW-1] and any signed dE.
        n_val      = $signed({2'b00, demon_energy}) - $signed({delta_q[DW], delta_q});
        accept     = ~n_val[DW+1] && (n_val[DW:0] <= DMaxExt);
        last_spin  = (calc_idx == IW'(N_SPINS - 1));
        last_sweep = (({1'b0, sweep_cnt_q} + 17'd1) == {1'b0, sweeps_q});
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sweeps_q     <= '0;
            sweep_cnt_q  <= '0;
            delta_q      <= '0;
            calc_req     <= 1'b0;
            calc_idx     <= '0;
            flip_valid   <= 1'b0;
            flip_idx     <= '0;
            demon_energy <= '0;
            accept_cnt   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            flip_valid <= 1'b0;
            done       <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                // Cancel: any flip this edge would have produced is dropped with the run.
                state_q  <= StIdle;
                calc_req <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            demon_energy <= demon_init;
                            sweeps_q     <= sweeps;
                            sweep_cnt_q  <= '0;
                            calc_idx     <= '0;
                            accept_cnt   <= '0;
                            busy         <= 1'b1;
                            if (sweeps == 16'd0) begin
                                state_q <= StDone;
                            end else begin
                                state_q  <= StReq;
                                calc_req <= 1'b1;
                            end
                        end
                    end
                    StReq: begin
                        if (calc_ack) begin
                            delta_q  <= calc_delta;
                            calc_req <= 1'b0;
                            state_q  <= StDecide;
                        end
                    end
                    StDecide: begin
                        if (accept) begin
                            demon_energy <= n_val[DW-1:0];
                            flip_valid   <= 1'b1;
                            flip_idx     <= calc_idx;
                            if (accept_cnt != 16'hFFFF) begin
                                accept_cnt <= accept_cnt + 16'd1;
                            end
                        end
                        if (last_spin) begin
                            calc_idx    <= '0;
                            sweep_cnt_q <= sweep_cnt_q + 16'd1;
                        end else begin
                            calc_idx <= calc_idx + IW'(1);
                        end
                        if (last_spin && last_sweep) begin
                            state_q <= StDone;
                        end else begin
                            state_q  <= StReq;
                            calc_req <= 1'b1;
                        end
                    end
                    StDone: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qubo_sweep_scheduler.sv
// tb_qubo_sweep_scheduler
// Randomized bench: a responder answers each dE request after a random delay and a
// spin-by-spin model (plain integer arithmetic) predicts flips, demon energy and counts.
module tb_qubo_sweep_scheduler;

    localparam int NS = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    demon_init;
    logic [15:0]   sweeps;
    logic          calc_req;
    logic [IW-1:0] calc_idx;
    logic          calc_ack;
    logic [8:0]    calc_delta;
    logic          flip_valid;
    logic [IW-1:0] flip_idx;
    logic [7:0]    demon_energy;
    logic [15:0]   accept_cnt;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_bad   = 0;
    int force_q[$];

    always #5 clk = ~clk;

    qubo_sweep_scheduler #(
        .N_SPINS (NS),
        .DW      (8),
        .D_MAX   (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .demon_init   (demon_init),
        .sweeps       (sweeps),
        .calc_req     (calc_req),
        .calc_idx     (calc_idx),
        .calc_ack     (calc_ack),
        .calc_delta   (calc_delta),
        .flip_valid   (flip_valid),
        .flip_idx     (flip_idx),
        .demon_energy (demon_energy),
        .accept_cnt   (accept_cnt),
        .busy         (busy),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_calc_req"}, 32'(calc_req), 0);
        check_eq({tag, "_calc_idx"}, 32'(calc_idx), 0);
        check_eq({tag, "_flip_valid"}, 32'(flip_valid), 0);
        check_eq({tag, "_flip_idx"}, 32'(flip_idx), 0);
        check_eq({tag, "_energy"}, 32'(demon_energy), 0);
        check_eq({tag, "_accept_cnt"}, 32'(accept_cnt), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
    endtask

    // One run: starts at a negedge, ends at a negedge with start/abort/reset low.
    // abort_req / reset_req give the request number (0-based) to cut the run at, or -1.
    task automatic do_run(input logic [7:0] init, input logic [15:0] nsw, input int maxdly,
                          input int abort_req, input int reset_req, input bit hold_start);
        int         d_exp, acc_exp, reqs, dly, cyc, tail, de_s, n, rst_stage;
        bit         pend, ending, finished;
        int         fq[$];
        int         dq[$];
        logic [8:0] de;
        d_exp = int'(init); acc_exp = 0; reqs = 0; dly = 0; cyc = 0; tail = 0; rst_stage = 0;
        pend = 0; ending = 0; finished = 0;
        start = 1'b1; demon_init = init; sweeps = nsw;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        // Inputs change after start; the run must use the latched copies.
        demon_init = 8'($urandom);
        sweeps     = 16'($urandom);
        check_eq("busy_after_start", 32'(busy), 1);
        while (!finished && cyc < 3000) begin
            calc_ack   = 1'b0;
            abort      = 1'b0;
            calc_delta = 9'($urandom);
            if (rst_stage == 2) begin
                reset = 1'b0;
                check_all_zero("after_reset");
                finished = 1;
            end else if (ending) begin
                check_eq("tail_busy", 32'(busy), 0);
                check_eq("tail_done", 32'(done), 0);
                check_eq("tail_flip", 32'(flip_valid), 0);
                check_eq("tail_req", 32'(calc_req), 0);
                tail++;
                if (tail >= 3) finished = 1;
            end else begin
                if (rst_stage == 1) begin
                    reset     = 1'b1;
                    rst_stage = 2;
                end
                if (flip_valid) begin
                    check_eq("flip_expected", 32'(fq.size() > 0), 1);
                    if (fq.size() > 0) begin
                        check_eq("flip_idx", 32'(flip_idx), fq.pop_front());
                        check_eq("flip_energy", 32'(demon_energy), dq.pop_front());
                    end
                end
                if (done) begin
                    start = 1'b0;
                    check_eq("done_busy", 32'(busy), 0);
                    check_eq("done_energy", 32'(demon_energy), d_exp);
                    check_eq("done_accept_cnt", 32'(accept_cnt), acc_exp);
                    check_eq("done_requests", reqs, nsw * NS);
                    check_eq("done_flips_left", fq.size(), 0);
                    ending = 1;
                end else if (calc_req) begin
                    if (!pend) begin
                        check_eq("calc_idx", 32'(calc_idx), reqs % NS);
                        reqs++;
                        pend = 1;
                        dly  = $urandom_range(0, maxdly);
                    end
                    if (reqs - 1 == abort_req) begin
                        abort  = 1'b1;
                        ending = 1;
                    end else if (dly == 0) begin
                        if (reqs - 1 == reset_req) de = 9'd0;
                        else if (force_q.size() > 0) de = 9'(force_q.pop_front());
                        else de = 9'($urandom);
                        calc_ack   = 1'b1;
                        calc_delta = de;
                        pend       = 0;
                        de_s       = $signed(de);
                        n          = d_exp - de_s;
                        if (reqs - 1 == reset_req) begin
                            rst_stage = 1;
                        end else if (n >= 0 && n <= 255) begin
                            d_exp = n;
                            fq.push_back((reqs - 1) % NS);
                            dq.push_back(n);
                            if (acc_exp < 65535) acc_exp++;
                        end
                    end else begin
                        dly--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    calc_ack = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("run_finished", 32'(finished), 1);
        start = 1'b0; abort = 1'b0; reset = 1'b0; calc_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; calc_ack = 1'b0;
        calc_delta = '0; demon_init = '0; sweeps = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Zero sweeps: busy for one cycle, done two cycles after start, no request.
        start = 1'b1; sweeps = 16'd0; demon_init = 8'd77;
        @(negedge clk);
        start = 1'b0;
        check_eq("t2_busy", 32'(busy), 1);
        check_eq("t2_done_early", 32'(done), 0);
        check_eq("t2_req", 32'(calc_req), 0);
        @(negedge clk);
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_busy_low", 32'(busy), 0);
        check_eq("t2_req2", 32'(calc_req), 0);
        check_eq("t2_energy", 32'(demon_energy), 77);
        @(negedge clk);
        check_eq("t2_done_pulse", 32'(done), 0);

        // Abort and start together in IDLE: no run.
        start = 1'b1; abort = 1'b1; sweeps = 16'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("abort_start_busy", 32'(busy), 0);
        check_eq("abort_start_req", 32'(calc_req), 0);

        // Worked example: flips 0,2,3, final energy 6.
        force_q = '{3, 3, -4, 0};
        do_run(8'd5, 16'd1, 0, -1, -1, 1'b0);
        check_eq("t1_accept_cnt", 32'(accept_cnt), 3);
        check_eq("t1_energy", 32'(demon_energy), 6);

        // Ceiling and floor boundaries: n=260 rejected, n=255 and n=0 accepted, n=-1 rejected.
        force_q = '{-10, -5, 255, 1};
        do_run(8'd250, 16'd1, 2, -1, -1, 1'b0);
        check_eq("t3_accept_cnt", 32'(accept_cnt), 2);
        check_eq("t3_energy", 32'(demon_energy), 0);

        // Three sweeps with random ack latency.
        do_run(8'd128, 16'd3, 5, -1, -1, 1'b0);

        // Abort while waiting on spin 2, then a clean fresh run.
        do_run(8'd120, 16'd2, 2, 2, -1, 1'b0);
        do_run(8'd60, 16'd1, 1, -1, -1, 1'b0);

        // Reset during DECIDE with an accept pending, then start held through a run.
        do_run(8'd100, 16'd2, 3, -1, 5, 1'b0);
        do_run(8'($urandom), 16'd2, 2, -1, -1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            do_run(8'($urandom), 16'($urandom_range(1, 4)), $urandom_range(0, 5), -1, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
